sar_conv_scheduler: RTL and testbench
=====================================

// Module: sar_conv_scheduler
// PURPOSE
//   Shares one SAR binary-search conversion engine between N_CH requesting channels.
//   Arbitrates requests round-robin and drives the analog mux select.
//   Waits a settling interval, then pulses the engine start and waits for its done.
//   Returns the result to the granted channel with a one-cycle ack.
//   Sits between the channel front-ends and the SAR FSM inside the top-level wrapper.
// PARAMETERS
//   N_CH        4    number of requesting channels (>=2)
//   NBITS       8    SAR result width
//   SETTLE_CYC  3    mux settling cycles between grant and sar_start (0 = skip SETTLE)
//   TIMEOUT     64   max cycles in WAIT for sar_done before abort (>=2)
// PORTS
//   clk         in   1                 system clock, rising edge
//   rst         in   1                 reset, asynchronous, active-high
//   req         in   N_CH              per-channel conversion request, level, held until ack
//   ack         out  N_CH              one-hot, one-cycle pulse: result valid for that channel
//   result      out  NBITS             last completed result; stable until next ack
//   ch_sel      out  $clog2(N_CH)      analog mux select, held from grant until return to IDLE
//   sar_start   out  1                 one-cycle start pulse to SAR engine
//   sar_done    in   1                 one-cycle completion pulse from SAR engine
//   sar_result  in   NBITS             engine result, valid when sar_done=1
//   busy        out  1                 1 in any state except IDLE
//   err         out  1                 one-cycle pulse on timeout abort
//   err_ch      out  $clog2(N_CH)      channel that timed out, valid with err, held after
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, rr pointer so channel 0 has top priority first.
//   FSM (all outputs registered/Moore):
//   - IDLE: if |req, grant = first set req at or after (last_grant+1) mod N_CH.
//     Load ch_sel and settle_cnt=SETTLE_CYC-1, -> SETTLE (-> START if SETTLE_CYC=0).
//   - SETTLE: decrement settle_cnt; at 0 -> START. Exactly SETTLE_CYC cycles.
//   - START: sar_start=1 for this single cycle; clear timeout counter; -> WAIT.
//   - WAIT: if sar_done, capture sar_result into result reg, -> DONE.
//     Else if tcnt==TIMEOUT-1, err=1 and err_ch=grant; last_grant<=grant; -> IDLE.
//     Else tcnt++. No ack on timeout; a still-held req re-arbitrates behind others.
//   - DONE: ack[grant]=1, result already valid; last_grant<=grant; -> IDLE.
//   Latency: req seen in IDLE at edge k gives sar_start high in cycle k+1+SETTLE_CYC.
//     If sar_done arrives d cycles after start, ack is high one cycle after done.
//   Fairness: a requester waits at most N_CH-1 conversions.
//   Boundaries:
//   - A req dropped after grant does not cancel the conversion; ack is still issued.
//   - sar_done outside WAIT is ignored. sar_done and timeout in the same cycle: done wins.
//   - req re-asserted or held during its own ack: arbitrated next IDLE, last_grant excluded
//     first.
//   - All req high: grants cycle 0,1,2,3,0,... with no skipped channel.
//   - rst mid-conversion: immediate IDLE, outputs cleared; SAR engine state not managed here.
//   - Back-to-back: IDLE lasts >=1 cycle between ack and the next grant.
// STRUCTURE
//   sar_pkg: state enum {IDLE,SETTLE,START,WAIT,DONE}, NBITS default, clog2 helper.
//   Sub-module sar_rr_arbiter: combinational round-robin pick.
//     Inputs: req, last_grant. Outputs: grant index and any_req.
//   Scheduler holds the FSM, counters, and registers.
// TESTING (engine model: sar_done N cycles after sar_start, result=f(ch_sel))
//   1. req=4'b0100, SETTLE_CYC=3, engine d=8.
//      -> ch_sel=2; sar_start 4 cycles after req sampled.
//      -> ack=4'b0100 one cycle after done; result=model(2); busy low next cycle.
//   2. req=4'b1111 held for 8 acks -> ack order 0,1,2,3,0,1,2,3.
//   3. Engine never answers on ch1.
//      -> err pulse at WAIT cycle 64 with err_ch=1, no ack; next grant is ch2 if req[2]=1.
//   4. sar_done pulsed during SETTLE -> ignored; real done in WAIT produces exactly one ack.
//   5. rst asserted in WAIT -> same-cycle async clear of busy, ch_sel, ack; next req restarts
//      from ch0.
//   6. req[3] dropped after grant -> conversion completes and ack[3] pulses once; no regrant.

Source files
------------

// File: rtl/sar_conv_scheduler_pkg.sv
// Shared types and helpers for the SAR conversion scheduler.
package sar_conv_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } sar_state_t;

  localparam int unsigned NBITS_DEF = 8;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd2) ? 32'd1 : unsigned'($clog2(v));
  endfunction

endpackage

// File: rtl/sar_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last_grant+1.
module sar_conv_scheduler_rr_arbiter
  import sar_conv_scheduler_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CW   = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   last_grant,
  output logic [CW-1:0]   grant,
  output logic            any_req
);

  int unsigned   idx;
  logic [CW-1:0] idx_c;
  logic          found;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(last_grant) + i + 32'd1;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CW'(idx);
      if (!found && req[idx_c]) begin
        found = 1'b1;
        grant = idx_c;
      end
    end
  end

endmodule

// File: rtl/sar_conv_scheduler.sv
// Shares one SAR engine between N_CH channels: round-robin grant, mux settle,
// start pulse, bounded wait for done, and a one-cycle ack per result.
module sar_conv_scheduler
  import sar_conv_scheduler_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned NBITS      = NBITS_DEF,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         ack,
  output logic [NBITS-1:0]        result,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic                    sar_start,
  input  logic                    sar_done,
  input  logic [NBITS-1:0]        sar_result,
  output logic                    busy,
  output logic                    err,
  output logic [$clog2(N_CH)-1:0] err_ch
);

  localparam int unsigned CW  = clog2_min1(N_CH);
  localparam int unsigned SCW = clog2_min1(SETTLE_CYC);
  localparam int unsigned TCW = clog2_min1(TIMEOUT);
  localparam logic [SCW-1:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? '0 : SCW'(SETTLE_CYC - 1);
  localparam logic [TCW-1:0] TCNT_MAX    = TCW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  LAST_RST    = CW'(N_CH - 1);

  sar_state_t       state, state_nxt;
  logic [SCW-1:0]   settle_cnt, settle_cnt_nxt;
  logic [TCW-1:0]   tcnt, tcnt_nxt;
  logic [CW-1:0]    last_grant, last_grant_nxt;
  logic [CW-1:0]    ch_sel_nxt, err_ch_nxt;
  logic [NBITS-1:0] result_nxt;
  logic [N_CH-1:0]  ack_nxt;
  logic             busy_nxt, sar_start_nxt, err_nxt;
  logic [CW-1:0]    grant_c;
  logic             any_req_c;

  sar_conv_scheduler_rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_arb (
    .req       (req),
    .last_grant(last_grant),
    .grant     (grant_c),
    .any_req   (any_req_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; done takes precedence over timeout in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req_c) state_nxt = (SETTLE_CYC == 0) ? ST_START : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_START;
      ST_START:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (sar_done)              state_nxt = ST_DONE;
        else if (tcnt == TCNT_MAX) state_nxt = ST_IDLE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; Moore outputs are decoded from state_nxt
  always_comb begin
    settle_cnt_nxt = settle_cnt;
    tcnt_nxt       = tcnt;
    last_grant_nxt = last_grant;
    ch_sel_nxt     = ch_sel;
    err_ch_nxt     = err_ch;
    result_nxt     = result;
    err_nxt        = 1'b0;
    ack_nxt        = '0;
    case (state)
      ST_IDLE: begin
        if (any_req_c) begin
          ch_sel_nxt     = grant_c;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: if (settle_cnt != '0) settle_cnt_nxt = settle_cnt - SCW'(1);
      ST_START:  tcnt_nxt = '0;
      ST_WAIT: begin
        if (sar_done) begin
          result_nxt = sar_result;
        end else if (tcnt == TCNT_MAX) begin
          err_nxt        = 1'b1;
          err_ch_nxt     = ch_sel;
          last_grant_nxt = ch_sel;
        end else begin
          tcnt_nxt = tcnt + TCW'(1);
        end
      end
      ST_DONE:   last_grant_nxt = ch_sel;
      default:   ;
    endcase
    busy_nxt         = (state_nxt != ST_IDLE);
    sar_start_nxt    = (state_nxt == ST_START);
    ack_nxt[ch_sel]  = (state_nxt == ST_DONE);
  end

  // Registered outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      tcnt       <= '0;
      last_grant <= LAST_RST;
      ch_sel     <= '0;
      err_ch     <= '0;
      result     <= '0;
      err        <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
      sar_start  <= 1'b0;
    end else begin
      settle_cnt <= settle_cnt_nxt;
      tcnt       <= tcnt_nxt;
      last_grant <= last_grant_nxt;
      ch_sel     <= ch_sel_nxt;
      err_ch     <= err_ch_nxt;
      result     <= result_nxt;
      err        <= err_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      sar_start  <= sar_start_nxt;
    end
  end

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Directed bench for sar_conv_scheduler with a delayed-done SAR engine model.
module tb_sar_conv_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ack;
  logic [7:0] result;
  logic [1:0] ch_sel;
  logic       sar_start;
  logic       sar_done;
  logic [7:0] sar_result;
  logic       busy;
  logic       err;
  logic [1:0] err_ch;

  logic        eng_en, eng_done, spur_done;
  logic [7:0]  eng_res;
  int unsigned eng_d;
  int unsigned cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  assign sar_done   = eng_done | spur_done;
  assign sar_result = eng_res;

  sar_conv_scheduler #(.N_CH(4), .NBITS(8), .SETTLE_CYC(3), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .result    (result),
    .ch_sel    (ch_sel),
    .sar_start (sar_start),
    .sar_done  (sar_done),
    .sar_result(sar_result),
    .busy      (busy),
    .err       (err),
    .err_ch    (err_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: done eng_d cycles after start, result = 0x30 + 0x11*channel
  initial begin
    eng_done = 1'b0;
    eng_res  = '0;
    forever begin
      @(negedge clk);
      if (sar_start && eng_en) begin
        repeat (eng_d) @(negedge clk);
        eng_done = 1'b1;
        eng_res  = 8'h30 + 8'h11 * {6'b0, ch_sel};
        done_cyc = cyc;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output logic got);
    int n = 0;
    while (ack == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    got = (ack != '0);
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got no ack required ack within 300 cycles");
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!sar_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sar_start) begin
      n_vec++;
      n_err++;
      $display("FAIL start_timeout: got no sar_start required sar_start within 100 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    int unsigned d;
    logic [1:0]  ch;
    logic [3:0]  ack;
    logic [7:0]  res;
  } vec_t;

  vec_t tv [8];

  initial begin
    logic got;
    int   n, acks, busy_cnt;
    logic [3:0] ack_seen;
    logic [7:0] res_seen;
    logic saw_ack;

    // Round-robin walk from reset (last_grant starts at 3)
    tv[0] = '{4'b0100, 8, 2'd2, 4'b0100, 8'h52};
    tv[1] = '{4'b1111, 1, 2'd3, 4'b1000, 8'h63};
    tv[2] = '{4'b0011, 2, 2'd0, 4'b0001, 8'h30};
    tv[3] = '{4'b0011, 5, 2'd1, 4'b0010, 8'h41};
    tv[4] = '{4'b0001, 3, 2'd0, 4'b0001, 8'h30};
    tv[5] = '{4'b1001, 4, 2'd3, 4'b1000, 8'h63};
    tv[6] = '{4'b0110, 6, 2'd1, 4'b0010, 8'h41};
    tv[7] = '{4'b0110, 2, 2'd2, 4'b0100, 8'h52};

    rst = 1'b1; req = '0; eng_en = 1'b1; spur_done = 1'b0; eng_d = 8;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_start", sar_start, 0);
    chk("rst_err", err, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    // Table-driven single conversions
    for (int i = 0; i < 8; i++) begin
      eng_d = tv[i].d;
      @(negedge clk);
      req = tv[i].req;
      n = 0;
      while (!sar_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("start_lat", n, 4);
      chk("ch_sel", ch_sel, tv[i].ch);
      wait_ack(got);
      if (got) begin
        chk("ack", ack, tv[i].ack);
        chk("result", result, tv[i].res);
        chk("ack_after_done", cyc, done_cyc + 1);
      end
      req = '0;
      @(negedge clk);
      chk("busy_after_ack", busy, 0);
      chk("ack_pulse", ack, 0);
    end

    // All requests held: grants cycle 0,1,2,3,0,1,2,3 with an IDLE gap each time
    do_reset();
    eng_d = 2;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ack(got);
      if (got) chk("rr_order", ack, 4'b0001 << (i % 4));
      @(negedge clk);
      chk("rr_idle_gap", busy, 0);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Engine silent on ch1: timeout, no ack, then ch2 is served
    do_reset();
    eng_en = 1'b0;
    eng_d = 3;
    req = 4'b0110;
    wait_start();
    chk("to_ch_sel", ch_sel, 1);
    n = 0;
    saw_ack = 1'b0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
      if (ack != '0) saw_ack = 1'b1;
    end
    chk("to_err_lat", n, 65);
    chk("to_err_ch", err_ch, 1);
    chk("to_no_ack", saw_ack, 0);
    chk("to_busy", busy, 0);
    eng_en = 1'b1;
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    chk("to_regrant", ch_sel, 2);
    chk("to_err_ch_hold", err_ch, 1);
    wait_ack(got);
    if (got) chk("to_ack2", ack, 4'b0100);
    req = '0;
    repeat (3) @(negedge clk);

    // Spurious done during SETTLE is ignored; exactly one ack
    eng_d = 4;
    req = 4'b0001;
    @(negedge clk);
    chk("sp_busy", busy, 1);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    acks = 0;
    ack_seen = '0;
    res_seen = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        acks++;
        ack_seen = ack;
        res_seen = result;
        req = '0;
      end
    end
    chk("sp_ack_count", acks, 1);
    chk("sp_ack_val", ack_seen, 4'b0001);
    chk("sp_result", res_seen, 8'h30);

    // Reset in WAIT clears outputs at once; arbitration restarts at ch0
    eng_d = 20;
    @(negedge clk);
    req = 4'b0010;
    wait_start();
    repeat (3) @(negedge clk);
    chk("pre_rst_ch_sel", ch_sel, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ch_sel", ch_sel, 0);
    chk("arst_ack", ack, 0);
    chk("arst_start", sar_start, 0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (30) @(negedge clk);
    eng_d = 3;
    req = 4'b0011;
    @(negedge clk);
    chk("arst_regrant", ch_sel, 0);
    wait_ack(got);
    if (got) chk("arst_ack_ch0", ack, 4'b0001);
    req = '0;
    repeat (3) @(negedge clk);

    // req[3] dropped after grant: conversion completes, one ack, no regrant
    req = 4'b1000;
    @(negedge clk);
    chk("drop_busy", busy, 1);
    req = '0;
    wait_ack(got);
    if (got) chk("drop_ack", ack, 4'b1000);
    acks = 0;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (busy) busy_cnt++;
    end
    chk("drop_no_reack", acks, 0);
    chk("drop_no_regrant", busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
